// File: rtl/rv32_uart_tx_mmio.sv
// rtl/rv32_uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Purpose: sits on the core data bus next to data_memory. Stores to TXDATA
// queue bytes in a small FIFO; a frame engine pops them and shifts them out
// LSB first as start + 8 data + stop bits, each bit lasting BAUDDIV clocks.
// Register window (16 bytes at BASE):
//   +0 TXDATA  W: push wdata[7:0]          R: 0
//   +4 STATUS  R: {count, ovf, busy, empty, full}  W: wdata[3]=1 clears ovf
//   +8 BAUDDIV R/W [15:0] clocks per bit (0 is stored as 1)
//   +C reserved
// Ports:
//   clk      clock, all state on posedge
//   reset_n  synchronous active-low reset
//   address  byte address from core
//   read     load strobe
//   write    store strobe
//   wdata    store data
//   rdata    load data, combinational, 0 when not reading this block
//   sel      address falls inside the window, combinational
//   tx       registered serial output, idle high
module rv32_uart_tx_mmio #(
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter logic [AW-1:0]   BASE        = 'h800,
    parameter int              DEPTH       = 4,
    parameter logic [15:0]     DEFAULT_DIV = 16'd16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] address,
    input  logic          read,
    input  logic          write,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          sel,
    output logic          tx
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    logic [15:0]   div_q, div_d;
    logic          tx_q, tx_d;
    logic [15:0]   bauddiv_q;
    logic          ovf_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]    mem [DEPTH];

    logic [1:0]    reg_idx;
    logic          wr_en, push_req, do_push, pop;
    logic          full, empty, busy, baud_end;
    logic          unused_bits;

    assign sel      = (address[AW-1:4] == BASE[AW-1:4]);
    assign reg_idx  = address[3:2];
    assign wr_en    = write && sel;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign busy     = (state_q != S_IDLE);
    assign push_req = wr_en && (reg_idx == 2'd0);
    // A push into a full FIFO is dropped even if the engine pops this cycle.
    assign do_push  = push_req && !full;
    assign baud_end = (baud_cnt_q == div_q - 16'd1);
    assign tx       = tx_q;
    assign unused_bits = ^{address[1:0], wdata[DW-1:16]};

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            baud_cnt_q <= '0;
            div_q      <= DEFAULT_DIV;
            tx_q       <= 1'b1;
            bauddiv_q  <= DEFAULT_DIV;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
            count_q    <= count_q + CW'(do_push) - CW'(pop);
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_req && full) begin
                ovf_q <= 1'b1;
            end else if (wr_en && reg_idx == 2'd1 && wdata[3]) begin
                ovf_q <= 1'b0;
            end
            if (wr_en && reg_idx == 2'd2) begin
                bauddiv_q <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata[7:0];
    end

    // Next-state logic; a pop always reloads shift and re-latches the divider
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_d    = S_START;
                    shift_d    = mem[rd_ptr_q];
                    div_d      = bauddiv_q;
                    baud_cnt_d = '0;
                    bit_d      = '0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d    = S_DATA;
                    baud_cnt_d = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    if (!empty) begin
                        // Back-to-back frame: no idle bit between stop and start
                        pop     = 1'b1;
                        state_d = S_START;
                        shift_d = mem[rd_ptr_q];
                        div_d   = bauddiv_q;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: tx is registered, so it is derived from the next state
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (read && sel) begin
            case (reg_idx)
                2'd1:    rdata = DW'({4'(count_q), ovf_q, busy, empty, full});
                2'd2:    rdata = DW'(bauddiv_q);
                default: rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_uart_tx_mmio.sv
// tb/tb_rv32_uart_tx_mmio.sv - self-checking bench for rv32_uart_tx_mmio
module tb_rv32_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'h800;
    localparam int HN = 16384;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        sel;
    logic        tx;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic tx_hist [HN];

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] exp_rdata;
        logic        exp_sel;
        string       nm;
    } vec_t;
    vec_t vecs [8];

    rv32_uart_tx_mmio dut (
        .clk     (clk),
        .reset_n (reset_n),
        .address (address),
        .read    (read),
        .write   (write),
        .wdata   (wdata),
        .rdata   (rdata),
        .sel     (sel),
        .tx      (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // tx_hist[k] holds tx as seen after posedge number k
    always @(negedge clk) if (cyc < HN) tx_hist[cyc] = tx;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int e);
        address = a;
        wdata   = d;
        write   = 1'b1;
        tick();
        e       = cyc;
        write   = 1'b0;
        address = '0;
        wdata   = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        #1;
        d       = rdata;
        read    = 1'b0;
        address = '0;
    endtask

    // Reference frame: bit slot 0 = start(0), slots 1..8 = data LSB first,
    // slot 9 = stop(1); each slot must hold its value for d cycles.
    task automatic check_frame(input string nm, input int start, input int d, input logic [7:0] b);
        logic [9:0] exp_bits;
        logic [9:0] got_bits;
        logic       stable;
        exp_bits = {1'b1, b, 1'b0};
        stable   = 1'b1;
        for (int s = 0; s < 10; s++) begin
            got_bits[s] = tx_hist[start + s * d];
            for (int c = 1; c < d; c++)
                if (tx_hist[start + s * d + c] !== got_bits[s]) stable = 1'b0;
        end
        check(nm, {21'd0, stable, got_bits}, {21'd0, 1'b1, exp_bits});
    endtask

    task automatic check_idle(input string nm, input int start, input int len);
        int zeros;
        zeros = 0;
        for (int k = start; k < start + len; k++)
            if (tx_hist[k] !== 1'b1) zeros++;
        check(nm, zeros, 0);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic r, input logic [31:0] e,
                                input logic s, input string nm);
        vec_t v;
        v.addr = a; v.rd = r; v.exp_rdata = e; v.exp_sel = s; v.nm = nm;
        return v;
    endfunction

    initial begin
        int          e, n, r_edge, d, nb;
        int          s [5];
        logic [7:0]  bytes [4];
        logic [31:0] r;

        // Reset
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check("reset_tx", {31'd0, tx}, 1);

        // Register decode table after reset
        vecs[0] = mk(BASE + 32'h0,  1'b1, 32'h0,  1'b1, "txdata_rd");
        vecs[1] = mk(BASE + 32'h4,  1'b1, 32'h02, 1'b1, "status_rd");
        vecs[2] = mk(BASE + 32'h8,  1'b1, 32'd16, 1'b1, "baud_rd");
        vecs[3] = mk(BASE + 32'hC,  1'b1, 32'h0,  1'b1, "rsvd_rd");
        vecs[4] = mk(BASE + 32'h7,  1'b1, 32'h02, 1'b1, "status_lowbits");
        vecs[5] = mk(BASE + 32'h4,  1'b0, 32'h0,  1'b1, "no_read");
        vecs[6] = mk(BASE + 32'h10, 1'b1, 32'h0,  1'b0, "above_window");
        vecs[7] = mk(BASE - 32'h4,  1'b1, 32'h0,  1'b0, "below_window");
        for (int i = 0; i < 8; i++) begin
            address = vecs[i].addr;
            read    = vecs[i].rd;
            #1;
            check({vecs[i].nm, "_rdata"}, rdata, vecs[i].exp_rdata);
            check({vecs[i].nm, "_sel"}, {31'd0, sel}, {31'd0, vecs[i].exp_sel});
            read    = 1'b0;
            address = '0;
            tick();
        end

        // BAUDDIV upper bits, reserved writes, out-of-window stores
        bus_write(BASE + 32'h8, 32'hFFFF0003, e);
        bus_read(BASE + 32'h8, r);
        check("baud_upper_bits", r, 32'd3);
        bus_write(BASE + 32'hC, 32'h1234, e);
        bus_read(BASE + 32'hC, r);
        check("rsvd_write_ignored", r, 32'h0);
        bus_write(BASE + 32'h10, 32'h55, e);
        bus_read(BASE + 32'h4, r);
        check("outside_no_push", r, 32'h02);
        repeat (5) tick();
        check_idle("outside_no_tx", e, 5);

        // Single frame at div=4
        bus_write(BASE + 32'h8, 32'd4, e);
        bus_write(BASE + 32'h0, 32'hA5, n);
        repeat (45) tick();
        check("a5_before_pop", {31'd0, tx_hist[n]}, 1);
        check_frame("a5_frame", n + 1, 4, 8'hA5);
        check_idle("a5_idle_after", n + 41, 4);

        // Five back-to-back writes at div=2
        bus_write(BASE + 32'h8, 32'd2, e);
        for (int i = 0; i < 5; i++) bus_write(BASE + 32'h0, i + 1, s[i]);
        n = s[0];
        bus_read(BASE + 32'h4, r);
        check("b2b_status_full", r, 32'h45);
        repeat (105) tick();
        for (int k = 0; k < 5; k++)
            check_frame($sformatf("b2b_frame%0d", k), n + 1 + 20 * k, 2, 8'(k + 1));
        check_idle("b2b_idle_after", n + 101, 4);

        // Overflow: sixth byte dropped and sticky ovf, then cleared
        for (int i = 0; i < 5; i++) bus_write(BASE + 32'h0, 32'h11 * (i + 1), s[i]);
        n = s[0];
        bus_write(BASE + 32'h0, 32'hFF, e);
        bus_read(BASE + 32'h4, r);
        check("ovf_status", r, 32'h4D);
        bus_write(BASE + 32'h4, 32'h08, e);
        bus_read(BASE + 32'h4, r);
        check("ovf_cleared", r, 32'h45);
        repeat (135) tick();
        for (int k = 0; k < 5; k++)
            check_frame($sformatf("ovf_frame%0d", k), n + 1 + 20 * k, 2, 8'(8'h11 * (k + 1)));
        check_idle("ovf_ff_never_sent", n + 101, 30);

        // BAUDDIV change mid-frame applies only to the next frame
        bus_write(BASE + 32'h8, 32'd4, e);
        bus_write(BASE + 32'h0, 32'h3C, n);
        repeat (3) tick();
        bus_write(BASE + 32'h8, 32'd8, e);
        bus_write(BASE + 32'h0, 32'hC3, e);
        bus_read(BASE + 32'h8, r);
        check("baud_mid_rd", r, 32'd8);
        repeat (130) tick();
        check_frame("div_old_frame", n + 1, 4, 8'h3C);
        check_frame("div_new_frame", n + 41, 8, 8'hC3);
        check_idle("div_idle_after", n + 121, 4);
        bus_write(BASE + 32'h8, 32'd0, e);
        bus_read(BASE + 32'h8, r);
        check("baud_zero_is_one", r, 32'd1);

        // Reset mid-DATA with bytes queued
        bus_write(BASE + 32'h8, 32'd4, e);
        bus_write(BASE + 32'h0, 32'h0F, n);
        bus_write(BASE + 32'h0, 32'hF0, e);
        bus_write(BASE + 32'h0, 32'h81, e);
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        r_edge = cyc;
        check("rst_mid_tx", {31'd0, tx}, 1);
        bus_read(BASE + 32'h4, r);
        check("rst_mid_status", r, 32'h02);
        reset_n = 1'b1;
        bus_read(BASE + 32'h8, r);
        check("rst_mid_baud", r, 32'd16);
        repeat (60) tick();
        check_idle("rst_no_start", r_edge, 60);

        // Randomized frames against the reference frame model
        for (int it = 0; it < 6; it++) begin
            d  = $urandom_range(1, 5);
            nb = $urandom_range(1, 4);
            bus_write(BASE + 32'h8, d, e);
            for (int j = 0; j < nb; j++) begin
                bytes[j] = 8'($urandom_range(0, 255));
                bus_write(BASE + 32'h0, {24'd0, bytes[j]}, s[j]);
            end
            n = s[0];
            repeat (10 * d * nb + 6) tick();
            for (int j = 0; j < nb; j++)
                check_frame($sformatf("rnd%0d_frame%0d", it, j), n + 1 + 10 * d * j, d, bytes[j]);
            check_idle($sformatf("rnd%0d_idle", it), n + 1 + 10 * d * nb, 4);
            bus_read(BASE + 32'h4, r);
            check($sformatf("rnd%0d_status", it), r, 32'h02);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
